// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the width-converting FIFO: pointer/count width helpers
// and the legality check for the write-to-read width ratio.
// No ports (package).
// -----------------------------------------------------------------------------
package fifo_pkg;

   // Largest supported number of read words per write beat.
   localparam int MAX_RATIO = 32'sd8;

   // Number of read-word entries for a given address width.
   function automatic int depth_of(input int addr_w);
      return 32'sd1 << addr_w;
   endfunction

   // Count must represent 0..DEPTH inclusive, so it needs one extra bit.
   function automatic int cnt_width(input int addr_w);
      return addr_w + 32'sd1;
   endfunction

   // A ratio is legal when it is a power of two in 1..MAX_RATIO and a
   // single beat fits in the storage.
   function automatic bit ratio_legal(input int ratio, input int depth);
      bit pow2;
      pow2 = (ratio == 32'sd1) || (ratio == 32'sd2) ||
             (ratio == 32'sd4) || (ratio == 32'sd8);
      return pow2 && (ratio <= MAX_RATIO) && (ratio <= depth);
   endfunction

endpackage

// File: rtl/fifo_wconv_if.sv
// -----------------------------------------------------------------------------
// fifo_wconv_if
// Handshake/data bundle of the width-converting FIFO.
//   wr, w_data, rd            : requests and write beat (master -> FIFO)
//   r_data                    : head word, first-word-fall-through
//   empty, full, almost_full  : status flags
//   count                     : stored read words
//   ovf, udf                  : sticky dropped-write / dropped-read flags
// -----------------------------------------------------------------------------
interface fifo_wconv_if
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int RATIO      = 2
);
   logic                            wr;
   logic [RATIO*DATA_WIDTH-1:0]     w_data;
   logic                            rd;
   logic [DATA_WIDTH-1:0]           r_data;
   logic                            empty;
   logic                            full;
   logic                            almost_full;
   logic [cnt_width(ADDR_WIDTH)-1:0] count;
   logic                            ovf;
   logic                            udf;

   modport master (
      output wr, w_data, rd,
      input  r_data, empty, full, almost_full, count, ovf, udf
   );

   modport slave (
      input  wr, w_data, rd,
      output r_data, empty, full, almost_full, count, ovf, udf
   );
endinterface

// File: rtl/fifo_wconv_mem.sv
// -----------------------------------------------------------------------------
// fifo_wconv_mem
// Storage array with RATIO write lanes landing at w_ptr_i..w_ptr_i+RATIO-1
// (modulo DEPTH, lowest slice at the lowest address) and one asynchronous
// read port. Contents are intentionally not reset.
//   clk      : clock
//   we_i     : write enable for a full beat
//   w_ptr_i  : address of the first lane
//   w_data_i : beat, slice 0 is the oldest word
//   r_ptr_i  : read address
//   r_data_o : mem[r_ptr_i]
// -----------------------------------------------------------------------------
module fifo_wconv_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int RATIO      = 2
) (
   input  logic                        clk,
   input  logic                        we_i,
   input  logic [ADDR_WIDTH-1:0]       w_ptr_i,
   input  logic [RATIO*DATA_WIDTH-1:0] w_data_i,
   input  logic [ADDR_WIDTH-1:0]       r_ptr_i,
   output logic [DATA_WIDTH-1:0]       r_data_o
);
   localparam int DEPTH = depth_of(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Beat write: lane address wraps naturally in ADDR_WIDTH bits.
   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int l = 0; l < RATIO; l++) begin
            mem_q[w_ptr_i + ADDR_WIDTH'(l)] <= w_data_i[l*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign r_data_o = mem_q[r_ptr_i];

endmodule

// File: rtl/fifo_wconv.sv
// -----------------------------------------------------------------------------
// fifo_wconv
// Synchronous FIFO that accepts RATIO read words per write beat and returns
// one word per read. Pointer, count and flag logic live here; storage is in
// fifo_wconv_mem.
//   clk   : clock, rising edge
//   reset : synchronous, active-low
//   bus   : fifo_wconv_if.slave (requests, data, flags, count, ovf/udf)
// -----------------------------------------------------------------------------
module fifo_wconv
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int RATIO      = 2,
   parameter int AF_LEVEL   = depth_of(ADDR_WIDTH) - 32'sd4
) (
   input  logic        clk,
   input  logic        reset,
   fifo_wconv_if.slave bus
);
   localparam int DEPTH    = depth_of(ADDR_WIDTH);
   localparam int CNT_W    = cnt_width(ADDR_WIDTH);
   localparam bit RATIO_OK = ratio_legal(RATIO, DEPTH);

   if (!RATIO_OK) begin : g_bad_ratio
      $fatal(1, "fifo_wconv: RATIO must be a power of two in 1..8 and <= DEPTH");
   end

   logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
   logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic                  rd_acc_s;
   logic                  wr_acc_s;
   logic                  empty_s;
   logic [CNT_W:0]        need_s;
   logic [DATA_WIDTH-1:0] mem_rdata_s;

   assign empty_s = (count_q == '0);

   // Acceptance: a read frees a slot for a same-cycle write, so the write
   // check uses the post-read occupancy. One extra bit keeps the sum exact.
   always_comb begin
      rd_acc_s = bus.rd & ~empty_s;
      need_s   = {1'b0, count_q} + (CNT_W+1)'(RATIO) - {{CNT_W{1'b0}}, rd_acc_s};
      wr_acc_s = bus.wr & (need_s <= (CNT_W+1)'(DEPTH));
   end

   // Next-state for pointers, count and sticky error flags.
   always_comb begin
      w_ptr_d = w_ptr_q;
      r_ptr_d = r_ptr_q;
      ovf_d   = ovf_q;
      udf_d   = udf_q;
      if (wr_acc_s) begin
         w_ptr_d = w_ptr_q + ADDR_WIDTH'(RATIO);
      end else begin
         ovf_d = ovf_q | bus.wr;
      end
      if (rd_acc_s) begin
         r_ptr_d = r_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         udf_d = udf_q | bus.rd;
      end
      count_d = count_q
              + (wr_acc_s ? CNT_W'(RATIO) : {CNT_W{1'b0}})
              - {{(CNT_W-1){1'b0}}, rd_acc_s};
   end

   // State registers; reset wins over any request in the same cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         w_ptr_q <= '0;
         r_ptr_q <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         w_ptr_q <= w_ptr_d;
         r_ptr_q <= r_ptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   fifo_wconv_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .RATIO      (RATIO)
   ) u_mem (
      .clk      (clk),
      .we_i     (wr_acc_s),
      .w_ptr_i  (w_ptr_q),
      .w_data_i (bus.w_data),
      .r_ptr_i  (r_ptr_q),
      .r_data_o (mem_rdata_s)
   );

   // Flags depend only on the registered count; stale memory is masked
   // while empty so r_data reads 0 after reset.
   assign bus.r_data      = empty_s ? {DATA_WIDTH{1'b0}} : mem_rdata_s;
   assign bus.empty       = empty_s;
   assign bus.full        = (count_q > CNT_W'(DEPTH - RATIO));
   assign bus.almost_full = (count_q >= CNT_W'(AF_LEVEL));
   assign bus.count       = count_q;
   assign bus.ovf         = ovf_q;
   assign bus.udf         = udf_q;

endmodule

// File: tb/tb_fifo_wconv.sv
module tb_fifo_wconv;
   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int RATIO = 2;
   localparam int DEPTH = 16;
   localparam int AFL   = 12;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   fifo_wconv_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RATIO(RATIO)) bus ();

   fifo_wconv #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .RATIO      (RATIO),
      .AF_LEVEL   (AFL)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: a queue of read words plus sticky flags.
   logic [7:0] q[$];
   bit         m_ovf;
   bit         m_udf;
   int         passed = 0;
   int         total  = 0;
   int         fails  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int n;
      logic [7:0] er;
      n  = q.size();
      er = (n > 0) ? q[0] : 8'h00;
      check({tag, " count"}, 32'(bus.count),       32'(n));
      check({tag, " empty"}, 32'(bus.empty),       32'(n == 0));
      check({tag, " full"},  32'(bus.full),        32'(n > DEPTH - RATIO));
      check({tag, " afull"}, 32'(bus.almost_full), 32'(n >= AFL));
      check({tag, " ovf"},   32'(bus.ovf),         32'(m_ovf));
      check({tag, " udf"},   32'(bus.udf),         32'(m_udf));
      check({tag, " rdata"}, 32'(bus.r_data),      32'(er));
   endtask

   // One clock with the given requests; model updated from pre-edge state.
   task automatic cycle(input bit w, input bit r, input logic [15:0] d);
      int n;
      bit rda;
      bit wra;
      n   = q.size();
      rda = r && (n > 0);
      wra = w && (n - int'(rda) + RATIO <= DEPTH);
      bus.wr     = w;
      bus.rd     = r;
      bus.w_data = d;
      @(posedge clk);
      #1;
      if (w && !wra) m_ovf = 1'b1;
      if (r && n == 0) m_udf = 1'b1;
      if (rda) void'(q.pop_front());
      if (wra) begin
         for (int k = 0; k < RATIO; k++) q.push_back(d[k*8 +: 8]);
      end
      bus.wr = 1'b0;
      bus.rd = 1'b0;
   endtask

   task automatic do_reset(input int ncyc, input bit w);
      reset      = 1'b0;
      bus.wr     = w;
      bus.rd     = w;
      bus.w_data = 16'h5A5A;
      repeat (ncyc) @(posedge clk);
      #1;
      q.delete();
      m_ovf      = 1'b0;
      m_udf      = 1'b0;
      reset      = 1'b1;
      bus.wr     = 1'b0;
      bus.rd     = 1'b0;
   endtask

   initial begin
      int popped;
      int cyc;
      bit w;
      bit r;
      bus.wr     = 1'b0;
      bus.rd     = 1'b0;
      bus.w_data = 16'h0000;

      // Reset state
      do_reset(2, 1'b0);
      check_all("reset");
      check("reset rdata0", 32'(bus.r_data), 32'h0);

      // Single beat, then two reads
      cycle(1'b1, 1'b0, 16'hBBAA);
      check_all("beat");
      check("beat AA", 32'(bus.r_data), 32'hAA);
      cycle(1'b0, 1'b1, 16'h0000);
      check_all("rd1");
      check("rd1 BB", 32'(bus.r_data), 32'hBB);
      cycle(1'b0, 1'b1, 16'h0000);
      check_all("rd2");

      // Fill to the top, then one rejected beat
      for (int i = 0; i < 9; i++) begin
         cycle(1'b1, 1'b0, 16'($urandom));
         check_all("fill");
      end
      check("fill ovf", 32'(bus.ovf), 32'h1);
      check("fill count16", 32'(bus.count), 32'd16);
      // Drain: contents must be exactly the 8 accepted beats
      for (int i = 0; i < 16; i++) begin
         cycle(1'b0, 1'b1, 16'h0000);
         check_all("drain");
      end

      // Concurrent read/write at the boundary
      do_reset(1, 1'b0);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 16'($urandom));
      cycle(1'b0, 1'b1, 16'h0000);
      check_all("at15");
      cycle(1'b1, 1'b1, 16'hC3C2);
      check_all("rw15");
      check("rw15 ovf0", 32'(bus.ovf), 32'h0);
      cycle(1'b1, 1'b1, 16'hD5D4);
      check_all("rw16");
      check("rw16 ovf1", 32'(bus.ovf), 32'h1);
      check("rw16 count15", 32'(bus.count), 32'd15);

      // Underflow with a same-cycle write
      do_reset(1, 1'b0);
      cycle(1'b1, 1'b1, 16'h2211);
      check_all("udf");
      check("udf r11", 32'(bus.r_data), 32'h11);

      // Random stream with wrap-around, at least 100 words read out
      popped = 0;
      cyc    = 0;
      while (popped < 100 && cyc < 2000) begin
         w = ($urandom_range(0, 2) != 0) && (q.size() < 12 || $urandom_range(0, 3) == 0);
         r = ($urandom_range(0, 1) != 0);
         if (r && q.size() > 0) popped++;
         cycle(w, r, 16'($urandom));
         check_all("rand");
         cyc++;
      end
      check("stream done", 32'(popped >= 100), 32'h1);

      // Reset with a simultaneous write
      do_reset(1, 1'b1);
      check_all("rst_wr");
      check("rst_wr empty", 32'(bus.empty), 32'h1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/fifo_wconv.md
FIFO_WCONV -- requirements
Module: fifo_wconv

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the read word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, giving DEPTH = 2**ADDR_WIDTH read-word entries.
REQ-003 The block SHALL have parameter RATIO, default 2, giving the number of read words per write beat; legal values are powers of two, 1..8, with RATIO <= DEPTH.
REQ-004 The block SHALL have parameter AF_LEVEL, default DEPTH-4, giving the almost_full threshold in read words.
REQ-005 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 wr  input  1  write request for one beat of RATIO words.
REQ-008 w_data  input  RATIO*DATA_WIDTH  write beat; slice [DATA_WIDTH-1:0] SHALL be the oldest word.
REQ-009 rd  input  1  read request; pops the head word.
REQ-010 r_data  output  DATA_WIDTH  head word (first-word-fall-through).
REQ-011 empty  output  1  count == 0.
REQ-012 full  output  1  count > DEPTH-RATIO, meaning a write without a same-cycle read cannot be accepted.
REQ-013 almost_full  output  1  count >= AF_LEVEL.
REQ-014 count  output  ADDR_WIDTH+1  number of stored read words, 0..DEPTH.
REQ-015 ovf  output  1  sticky flag for a dropped write.
REQ-016 udf  output  1  sticky flag for a dropped read.

Function
REQ-017 A read SHALL be accepted when rd=1 and empty=0, regardless of wr in the same cycle.
REQ-018 A write SHALL be accepted when wr=1 and count - rd_accepted + RATIO <= DEPTH, evaluated in the same cycle.
REQ-019 An accepted write SHALL store RATIO words at consecutive addresses from w_ptr, lowest slice first, and advance w_ptr by RATIO modulo DEPTH.
REQ-020 An accepted read SHALL advance r_ptr by 1 modulo DEPTH.
REQ-021 On each clock edge, count SHALL become count + RATIO*wr_accepted - rd_accepted.
REQ-022 r_data SHALL be combinationally equal to mem[r_ptr] when empty=0, and SHALL be 0 when empty=1.
REQ-023 A written word SHALL appear on r_data in the cycle after the write is accepted (write-to-read latency of 1).
REQ-024 A rejected write (wr=1, not accepted) SHALL leave the memory, pointers and count unchanged and SHALL set ovf on the next edge.
REQ-025 A rejected read (rd=1, empty=1) SHALL set udf on the next edge; a same-cycle accepted write SHALL proceed unaffected.
REQ-026 ovf and udf SHALL remain set until reset.
REQ-027 Flags empty, full, almost_full and count SHALL be registered or derived from registered count only, with no combinational path from rd or wr.
REQ-028 Pointer wrap-around SHALL be seamless; data order SHALL be preserved across any number of wraps.

Reset
REQ-029 When reset=0 at a rising edge, w_ptr, r_ptr and count SHALL go to 0, and empty SHALL go to 1, full, almost_full, ovf and udf to 0, and r_data to 0, overriding any simultaneous rd or wr.
REQ-030 Memory contents SHALL NOT be cleared by reset; reset asserted mid-stream SHALL discard all stored words.

Structure
REQ-031 The shared package fifo_pkg SHALL hold the count/pointer width helpers and the ratio-legality check constant; the block SHALL fail elaboration for an illegal RATIO.
REQ-032 Storage SHALL be one sub-module, fifo_wconv_mem, with RATIO write lanes at w_ptr..w_ptr+RATIO-1 and one asynchronous read port.
REQ-033 Pointer, count and flag logic SHALL reside in fifo_wconv itself.

Verification (DATA_WIDTH=8, ADDR_WIDTH=4, RATIO=2, AF_LEVEL=12)
REQ-034 Reset: hold reset=0 for 2 cycles -> empty=1, count=0, full=0, ovf=0, udf=0, r_data=0.
REQ-035 Write 0xBBAA -> next cycle count=2, r_data=0xAA; then rd -> r_data=0xBB, count=1; then rd -> empty=1, r_data=0.
REQ-036 Fill: 7 writes -> count=14, almost_full=1, full=0; 8th write -> count=16, full=1; 9th write -> count=16, ovf=1, contents unchanged.
REQ-037 Concurrent at boundary: count=15, wr=1 and rd=1 -> both accepted, count=16; at count=16, wr=1 and rd=1 -> write rejected, ovf=1, count=15.
REQ-038 Underflow: empty, rd=1 and wr=1 with 0x2211 -> udf=1, count=2, r_data=0x11 next cycle.
REQ-039 Wrap and reset: stream 100 words at random rd/wr and check order against a scoreboard; then reset=0 with wr=1 -> count=0, empty=1.
